epp_out_reader: RTL and testbench

- Captures every CPU OUT write (OUT1 or OUT2, tagged by stream) into a small FIFO.
- Lets the host PC read the captured values back over the same EPP port that already loads programs and input data; this is the host-read counterpart of the program/input write path.
- Shares the EPP bus with the existing EPP interface block:
  - snoops every address-write cycle;
  - answers data cycles only for its own address window;
  - the top level ORs/muxes `EppWait` and the data bus.

---
 rtl/hovalaag_pkg.sv | 18 +
 rtl/epp_out_reader_if.sv | 20 ++
 rtl/out_fifo.sv | 61 ++++++
 rtl/epp_out_reader.sv | 169 ++++++++++++++++
 tb/tb_epp_out_reader.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hovalaag_pkg.sv
// Shared constants for the EPP out-reader: register offsets, FIFO entry width and FSM encoding.
package hovalaag_pkg;

  localparam logic [1:0] EPP_OUT_STATUS  = 2'd0;
  localparam logic [1:0] EPP_OUT_DATA_LO = 2'd1;
  localparam logic [1:0] EPP_OUT_DATA_HI = 2'd2;
  localparam logic [1:0] EPP_OUT_CTRL    = 2'd3;

  // {select, value[11:0]}
  localparam int unsigned EPP_OUT_ENTRY_W = 13;
  typedef logic [EPP_OUT_ENTRY_W-1:0] epp_out_entry_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

endpackage

// File: rtl/epp_out_reader_if.sv
// EPP bus as seen by the out-reader; master = host side, slave = reader side.
interface epp_out_reader_if;
  logic       EppAstb;
  logic       EppDstb;
  logic       EppWR;
  logic [7:0] EppDB_in;
  logic       EppWait;
  logic [7:0] EppDB_out;
  logic       EppDB_oe;

  modport master (
    output EppAstb, EppDstb, EppWR, EppDB_in,
    input  EppWait, EppDB_out, EppDB_oe
  );

  modport slave (
    input  EppAstb, EppDstb, EppWR, EppDB_in,
    output EppWait, EppDB_out, EppDB_oe
  );
endinterface

// File: rtl/out_fifo.sv
// Synchronous FIFO for captured OUT values with flush and optional drop-oldest on overflow.
module out_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             drop_oldest_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [4:0]       count_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [4:0]       count_q, count_d;
  logic             do_push, do_pop, rd_adv;

  assign empty_o = (count_q == 5'd0);
  assign full_o  = (count_q == 5'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    do_push = push_i && (!full_o || do_pop || drop_oldest_i);
    rd_adv  = do_pop || (push_i && full_o && drop_oldest_i);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = rd_adv ? rd_q + 1'b1 : rd_q;
    count_d = count_q + 5'(do_push) - 5'(rd_adv);
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = 5'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= 5'd0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/epp_out_reader.sv
// Host readback of CPU OUT writes over the shared EPP port.
// Define EPP_OUT_READER_DROP_OLDEST_EN to overwrite the oldest entry when the FIFO is full.
module epp_out_reader
  import hovalaag_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_valid,
  input  logic              capture_select,
  input  logic [11:0]       capture_data,
  epp_out_reader_if.slave   epp,
  output logic [4:0]        fifo_count
);
`ifdef EPP_OUT_READER_DROP_OLDEST_EN
  localparam logic DropOldest = 1'b1;
`else
  localparam logic DropOldest = 1'b0;
`endif

  logic           astb_meta_q, astb_q, dstb_meta_q, dstb_q;
  logic [1:0]     state_q, state_d;
  logic [7:0]     addr_q, addr_d;
  logic           cyc_addr_q, cyc_addr_d;
  logic           wait_q, wait_d, oe_q, oe_d;
  logic [7:0]     dout_q, dout_d;
  logic           act_pop_q, act_pop_d, act_clr_q, act_clr_d, act_flush_q, act_flush_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     off, new_off, rd_byte;
  logic [1:0]     reg_sel;
  logic           in_win, new_in_win, hold_exit;
  logic           fifo_pop, fifo_flush, fifo_empty, fifo_full;
  epp_out_entry_t head;

  assign off        = addr_q - BASE_ADDR;
  assign new_off    = epp.EppDB_in - BASE_ADDR;
  assign in_win     = (off < 8'd4);
  assign new_in_win = (new_off < 8'd4);
  assign reg_sel    = off[1:0];
  assign hold_exit  = (state_q == HOLD) && (cyc_addr_q ? astb_q : dstb_q);
  assign fifo_pop   = hold_exit && act_pop_q;
  assign fifo_flush = hold_exit && act_flush_q;

  assign epp.EppWait   = wait_q;
  assign epp.EppDB_oe  = oe_q;
  assign epp.EppDB_out = dout_q;

  out_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EPP_OUT_ENTRY_W)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (reset),
    .push_i       (capture_valid),
    .pop_i        (fifo_pop),
    .flush_i      (fifo_flush),
    .drop_oldest_i(DropOldest),
    .wdata_i      ({capture_select, capture_data}),
    .rdata_o      (head),
    .count_o      (fifo_count),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  always_comb begin
    rd_byte = 8'h00;
    unique case (reg_sel)
      EPP_OUT_STATUS:  rd_byte = {ovf_q, fifo_full, fifo_empty, fifo_count};
      EPP_OUT_DATA_LO: rd_byte = fifo_empty ? 8'h00 : head[7:0];
      EPP_OUT_DATA_HI: rd_byte = fifo_empty ? 8'h00 : {3'b000, head[12:8]};
      EPP_OUT_CTRL:    rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cyc_addr_d  = cyc_addr_q;
    wait_d      = wait_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    act_pop_d   = act_pop_q;
    act_clr_d   = act_clr_q;
    act_flush_d = act_flush_q;
    unique case (state_q)
      IDLE: begin
        if (!astb_q && !epp.EppWR) begin
          // Every address write is snooped; only in-window ones are acknowledged.
          state_d    = ADDR;
          addr_d     = epp.EppDB_in;
          cyc_addr_d = 1'b1;
          wait_d     = new_in_win;
        end else if (!dstb_q && in_win) begin
          state_d     = DATA;
          cyc_addr_d  = 1'b0;
          wait_d      = 1'b1;
          act_pop_d   = 1'b0;
          act_clr_d   = 1'b0;
          act_flush_d = 1'b0;
          if (epp.EppWR) begin
            oe_d      = 1'b1;
            dout_d    = rd_byte;
            act_pop_d = (reg_sel == EPP_OUT_DATA_HI) && !fifo_empty;
            act_clr_d = (reg_sel == EPP_OUT_STATUS);
          end else begin
            act_flush_d = (reg_sel == EPP_OUT_CTRL) && epp.EppDB_in[0];
          end
        end
      end
      ADDR, DATA: state_d = HOLD;
      HOLD: begin
        if (hold_exit) begin
          state_d     = IDLE;
          wait_d      = 1'b0;
          oe_d        = 1'b0;
          act_pop_d   = 1'b0;
          act_clr_d   = 1'b0;
          act_flush_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new overflow beats a STATUS-read clear; a flush beats everything.
  always_comb begin
    ovf_d = ovf_q;
    if (hold_exit && act_clr_q) ovf_d = 1'b0;
    if (capture_valid && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (fifo_flush) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      astb_meta_q <= 1'b1;
      astb_q      <= 1'b1;
      dstb_meta_q <= 1'b1;
      dstb_q      <= 1'b1;
      state_q     <= IDLE;
      addr_q      <= 8'h00;
      cyc_addr_q  <= 1'b0;
      wait_q      <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= 8'h00;
      act_pop_q   <= 1'b0;
      act_clr_q   <= 1'b0;
      act_flush_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      astb_meta_q <= epp.EppAstb;
      astb_q      <= astb_meta_q;
      dstb_meta_q <= epp.EppDstb;
      dstb_q      <= dstb_meta_q;
      state_q     <= state_d;
      addr_q      <= addr_d;
      cyc_addr_q  <= cyc_addr_d;
      wait_q      <= wait_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      act_pop_q   <= act_pop_d;
      act_clr_q   <= act_clr_d;
      act_flush_q <= act_flush_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_epp_out_reader.sv
// Directed bench for epp_out_reader: table-driven host transactions plus multi-cycle corner cases.
module tb_epp_out_reader;

  localparam logic [2:0] OpCap = 3'd0;
  localparam logic [2:0] OpAw  = 3'd1;
  localparam logic [2:0] OpRd  = 3'd2;
  localparam logic [2:0] OpWr  = 3'd3;
  localparam logic [2:0] OpCnt = 3'd4;

  typedef struct {
    logic [2:0]  op;
    logic [12:0] val;
    logic [7:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_valid;
  logic        capture_select;
  logic [11:0] capture_data;
  logic [4:0]  fifo_count;
  int          n_checks = 0;
  int          n_fail   = 0;

  epp_out_reader_if epp ();

  epp_out_reader #(
    .DEPTH    (16),
    .BASE_ADDR(8'h10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .capture_valid (capture_valid),
    .capture_select(capture_select),
    .capture_data  (capture_data),
    .epp           (epp),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic capture(input logic sel, input logic [11:0] data);
    @(negedge clk);
    capture_valid  = 1'b1;
    capture_select = sel;
    capture_data   = data;
    @(negedge clk);
    capture_valid  = 1'b0;
  endtask

  task automatic epp_aw(input logic [7:0] a, output logic ack);
    ack = 1'b0;
    epp.EppWR    = 1'b0;
    epp.EppDB_in = a;
    epp.EppAstb  = 1'b0;
    for (int i = 0; i < 8 && !ack; i++) begin
      @(negedge clk);
      if (epp.EppWait) ack = 1'b1;
    end
    epp.EppAstb = 1'b1;
    for (int i = 0; i < 8 && epp.EppWait; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic epp_rd(output logic [7:0] d, output logic ok);
    ok = 1'b0;
    epp.EppWR   = 1'b1;
    epp.EppDstb = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (epp.EppWait) ok = 1'b1;
    end
    d = epp.EppDB_out;
    epp.EppDstb = 1'b1;
    for (int i = 0; i < 20 && epp.EppWait; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic epp_wr(input logic [7:0] d, output logic ok);
    ok = 1'b0;
    epp.EppWR    = 1'b0;
    epp.EppDB_in = d;
    epp.EppDstb  = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (epp.EppWait) ok = 1'b1;
    end
    epp.EppDstb = 1'b1;
    for (int i = 0; i < 20 && epp.EppWait; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic addr_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    logic       ack, ok;
    logic [7:0] d;
    epp_aw(a, ack);
    check({name, " addr ack"}, {7'd0, ack}, 8'h01);
    epp_rd(d, ok);
    check({name, " ack"}, {7'd0, ok}, 8'h01);
    check(name, d, exp);
  endtask

  initial begin
    vec_t       vecs[$];
    logic       ack, ok, bad;
    logic [7:0] d, first_lo;

    // Basic readback, flush, empty reads and CTRL readback.
    vecs.push_back('{OpCap, 13'h0123, 8'h00});
    vecs.push_back('{OpCap, 13'h1ABC, 8'h00});
    vecs.push_back('{OpCnt, 13'h0000, 8'h02});
    vecs.push_back('{OpAw,  13'h0010, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'h02});
    vecs.push_back('{OpAw,  13'h0011, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'h23});
    vecs.push_back('{OpAw,  13'h0012, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'h01});
    vecs.push_back('{OpAw,  13'h0011, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'hBC});
    vecs.push_back('{OpAw,  13'h0012, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'h1A});
    vecs.push_back('{OpAw,  13'h0010, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'h20});
    vecs.push_back('{OpAw,  13'h0012, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'h00});
    vecs.push_back('{OpCnt, 13'h0000, 8'h00});
    for (int i = 1; i <= 5; i++) vecs.push_back('{OpCap, 13'(i), 8'h00});
    vecs.push_back('{OpCnt, 13'h0000, 8'h05});
    vecs.push_back('{OpAw,  13'h0013, 8'h00});
    vecs.push_back('{OpWr,  13'h0001, 8'h00});
    vecs.push_back('{OpCnt, 13'h0000, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'h00});
    vecs.push_back('{OpAw,  13'h0010, 8'h00});
    vecs.push_back('{OpRd,  13'h0000, 8'h20});

    reset          = 1'b1;
    capture_valid  = 1'b0;
    capture_select = 1'b0;
    capture_data   = 12'h000;
    epp.EppAstb    = 1'b1;
    epp.EppDstb    = 1'b1;
    epp.EppWR      = 1'b1;
    epp.EppDB_in   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset wait", {7'd0, epp.EppWait}, 8'h00);
    check("reset oe", {7'd0, epp.EppDB_oe}, 8'h00);
    check("reset dout", epp.EppDB_out, 8'h00);
    check("reset count", {3'd0, fifo_count}, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OpCap: capture(vecs[i].val[12], vecs[i].val[11:0]);
        OpAw: begin
          epp_aw(vecs[i].val[7:0], ack);
          check($sformatf("vec%0d addr ack", i), {7'd0, ack}, 8'h01);
        end
        OpRd: begin
          epp_rd(d, ok);
          check($sformatf("vec%0d read ack", i), {7'd0, ok}, 8'h01);
          check($sformatf("vec%0d read data", i), d, vecs[i].exp);
        end
        OpWr: begin
          epp_wr(vecs[i].val[7:0], ok);
          check($sformatf("vec%0d write ack", i), {7'd0, ok}, 8'h01);
        end
        default: begin
          @(negedge clk);
          check($sformatf("vec%0d count", i), {3'd0, fifo_count}, vecs[i].exp);
        end
      endcase
    end

    // Overflow: 17 captures into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) capture(1'b0, 12'(i));
`ifdef EPP_OUT_READER_DROP_OLDEST_EN
    first_lo = 8'h01;
`else
    first_lo = 8'h00;
`endif
    addr_read(8'h10, 8'hD0, "ovf status");
    addr_read(8'h11, first_lo, "ovf first data");
    addr_read(8'h10, 8'h50, "ovf status cleared");
    epp_aw(8'h13, ack);
    epp_wr(8'h01, ok);
    check("flush after ovf", {3'd0, fifo_count}, 8'h00);

    // Capture on the same edge as a DATA_HI pop of a full FIFO.
    for (int i = 0; i < 16; i++) capture(1'b0, 12'h100 + 12'(i));
    check("sim full count", {3'd0, fifo_count}, 8'h10);
    epp_aw(8'h12, ack);
    epp.EppWR   = 1'b1;
    epp.EppDstb = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (epp.EppWait) ok = 1'b1;
    end
    check("sim read ack", {7'd0, ok}, 8'h01);
    check("sim read data", epp.EppDB_out, 8'h01);
    epp.EppDstb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wait held until sync high", {7'd0, epp.EppWait}, 8'h01);
    capture_valid  = 1'b1;
    capture_select = 1'b1;
    capture_data   = 12'h5A5;
    @(negedge clk);
    capture_valid = 1'b0;
    check("wait falls after sync high", {7'd0, epp.EppWait}, 8'h00);
    check("sim count", {3'd0, fifo_count}, 8'h10);
    repeat (2) @(negedge clk);
    addr_read(8'h10, 8'h50, "sim status");
    epp_aw(8'h12, ack);
    for (int i = 0; i < 15; i++) begin
      epp_rd(d, ok);
      check($sformatf("drain%0d", i), d, 8'h01);
    end
    check("drain count", {3'd0, fifo_count}, 8'h01);
    addr_read(8'h11, 8'hA5, "last lo");
    addr_read(8'h12, 8'h15, "last hi");
    addr_read(8'h10, 8'h20, "drained status");

    // Foreign address: no acknowledge and no drive for the whole strobe.
    epp_aw(8'h05, ack);
    check("foreign addr ack", {7'd0, ack}, 8'h00);
    bad = 1'b0;
    epp.EppWR   = 1'b1;
    epp.EppDstb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bad = bad | epp.EppWait | epp.EppDB_oe;
    end
    epp.EppDstb = 1'b1;
    repeat (4) @(negedge clk);
    bad = bad | epp.EppWait | epp.EppDB_oe;
    check("foreign data quiet", {7'd0, bad}, 8'h00);

    // Reset during HOLD of a read.
    capture(1'b0, 12'h321);
    capture(1'b0, 12'h654);
    epp_aw(8'h11, ack);
    epp.EppWR   = 1'b1;
    epp.EppDstb = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (epp.EppWait) ok = 1'b1;
    end
    check("pre-reset ack", {7'd0, ok}, 8'h01);
    check("pre-reset oe", {7'd0, epp.EppDB_oe}, 8'h01);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset wait", {7'd0, epp.EppWait}, 8'h00);
    check("mid reset oe", {7'd0, epp.EppDB_oe}, 8'h00);
    check("mid reset count", {3'd0, fifo_count}, 8'h00);
    epp.EppDstb = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    capture(1'b0, 12'h777);
    addr_read(8'h11, 8'h77, "post reset lo");
    addr_read(8'h10, 8'h01, "post reset status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
